sipo_capture_shiftreg: RTL and testbench

- Serial-in/parallel-out receiver. It is the partner of the 4-bit PISO load-enable shift register.
- It takes the PISO's shiftOut stream, one bit per clock while shiftEn is high, MSB first, and rebuilds WIDTH-bit words.
- Each completed word is presented on a ready/valid output holding register, so a downstream consumer can stall without corrupting capture of the next word.
- An overrun is flagged when a word completes while the previous one is still unconsumed.

---
 rtl/sipo_capture_shiftreg_pkg.sv | 17 +
 rtl/sipo_capture_shiftreg_bit_counter.sv | 46 ++++
 rtl/sipo_capture_shiftreg.sv | 107 ++++++++++
 tb/tb_sipo_capture_shiftreg.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_capture_shiftreg_pkg.sv
// ============================================================================
// sipo_capture_shiftreg_pkg : shared types for the SIPO capture receiver
// Revision: 1.0
// ============================================================================
`default_nettype none

package sipo_capture_shiftreg_pkg;

    // Output holding-register occupancy
    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

`default_nettype wire

// File: rtl/sipo_capture_shiftreg_bit_counter.sv
// ============================================================================
// sipo_capture_shiftreg_bit_counter : mod-WIDTH up-counter, enable, sync clear
// Revision: 1.0
// ============================================================================
`default_nettype none

module sipo_capture_shiftreg_bit_counter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    assign tc    = (count_q == C_LAST);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tc ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sipo_capture_shiftreg.sv
// ============================================================================
// sipo_capture_shiftreg : serial-in/parallel-out receiver, ready/valid output
// Revision: 1.0
// ============================================================================
`default_nettype none

module sipo_capture_shiftreg
    import sipo_capture_shiftreg_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shiftIn,
    input  logic             shiftEn,
    input  logic             clear,
    output logic [WIDTH-1:0] regContent,
    output logic [CNT_W-1:0] bitCount,
    output logic [WIDTH-1:0] parallelOut,
    output logic             outValid,
    input  logic             outReady,
    output logic             overrun
);

    logic [WIDTH-1:0] shift_d,   shift_q;
    logic [WIDTH-1:0] hold_d,    hold_q;
    out_state_e       out_state_d, out_state_q;
    logic             overrun_d, overrun_q;

    logic             cnt_tc;
    logic             cnt_en;
    logic [WIDTH-1:0] word;
    logic             complete;
    logic             consume;
    logic             valid;

    assign cnt_en = shiftEn & ~clear;

    sipo_capture_shiftreg_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en),
        .clr   (clear),
        .count (bitCount),
        .tc    (cnt_tc)
    );

    // The completed word includes the bit arriving on this edge
    assign word     = {shift_q[WIDTH-2:0], shiftIn};
    assign valid    = (out_state_q == OUT_FULL);
    assign complete = cnt_en & cnt_tc;
    assign consume  = valid & outReady;

    always_comb begin
        shift_d = shift_q;
        if (clear) begin
            shift_d = '0;
        end else if (shiftEn) begin
            shift_d = word;
        end
    end

    always_comb begin
        hold_d      = hold_q;
        out_state_d = out_state_q;
        overrun_d   = overrun_q;
        if (complete) begin
            if (!valid || outReady) begin
                hold_d      = word;
                out_state_d = OUT_FULL;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (consume) begin
            out_state_d = OUT_EMPTY;
        end
        if (clear) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            hold_q      <= '0;
            out_state_q <= OUT_EMPTY;
            overrun_q   <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            out_state_q <= out_state_d;
            overrun_q   <= overrun_d;
        end
    end

    assign regContent  = shift_q;
    assign parallelOut = hold_q;
    assign outValid    = valid;
    assign overrun     = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_sipo_capture_shiftreg.sv
// ============================================================================
// tb_sipo_capture_shiftreg : directed bench for the SIPO capture receiver
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sipo_capture_shiftreg;

    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             shiftIn;
    logic             shiftEn;
    logic             clear;
    logic             outReady;
    logic [WIDTH-1:0] regContent;
    logic [CNT_W-1:0] bitCount;
    logic [WIDTH-1:0] parallelOut;
    logic             outValid;
    logic             overrun;

    int checks = 0;
    int errors = 0;

    sipo_capture_shiftreg #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .shiftIn     (shiftIn),
        .shiftEn     (shiftEn),
        .clear       (clear),
        .regContent  (regContent),
        .bitCount    (bitCount),
        .parallelOut (parallelOut),
        .outValid    (outValid),
        .outReady    (outReady),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs for one clock, then sample 1 time unit after the edge
    task automatic step(input logic en, input logic b);
        shiftEn = en;
        shiftIn = b;
        @(posedge clk);
        #1;
    endtask

    task automatic shift_word(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) step(1'b1, w[i]);
        shiftEn = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; outReady = 1'b0; clear = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, i[0]);
        checks++;
        if ({regContent, bitCount, parallelOut, outValid, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_hold: reg=%b cnt=%0d pout=%b v=%b ovr=%b, required all 0",
                     regContent, bitCount, parallelOut, outValid, overrun);
        end
        rst_n = 1'b1;
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
        checks++;
        if (outValid !== 1'b0) begin
            errors++; $display("FAIL first_word_early: outValid=%b required 0", outValid);
        end
        step(1'b1, 1'b1); shiftEn = 1'b0;
        checks++;
        if (parallelOut !== 4'b1011 || outValid !== 1'b1 || bitCount !== '0) begin
            errors++;
            $display("FAIL first_word: pout=%b v=%b cnt=%0d required 1011 1 0",
                     parallelOut, outValid, bitCount);
        end
    endtask

    task automatic test_gapped;
        outReady = 1'b1; clear = 1'b1;
        step(1'b0, 1'b0);
        clear = 1'b0; outReady = 1'b0;
        checks++;
        if (outValid !== 1'b0 || parallelOut !== 4'b1011 || regContent !== '0) begin
            errors++;
            $display("FAIL consume_clear: v=%b pout=%b reg=%b required 0 1011 0000",
                     outValid, parallelOut, regContent);
        end
        step(1'b1, 1'b1); step(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        checks++;
        if (regContent !== 4'b0011 || bitCount !== CNT_W'(2)) begin
            errors++;
            $display("FAIL gap_hold: reg=%b cnt=%0d required 0011 2", regContent, bitCount);
        end
        step(1'b1, 1'b0); step(1'b1, 1'b1); shiftEn = 1'b0;
        checks++;
        if (parallelOut !== 4'b1101 || outValid !== 1'b1) begin
            errors++;
            $display("FAIL gapped_word: pout=%b v=%b required 1101 1", parallelOut, outValid);
        end
    endtask

    task automatic test_back_to_back;
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        checks++;
        if (parallelOut !== 4'b1111 || outValid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_word1: pout=%b v=%b required 1111 1", parallelOut, outValid);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        shiftEn = 1'b0;
        checks++;
        if (parallelOut !== 4'b0000 || outValid !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_word2: pout=%b v=%b ovr=%b required 0000 1 0",
                     parallelOut, outValid, overrun);
        end
    endtask

    task automatic test_overrun;
        outReady = 1'b1;
        step(1'b0, 1'b0);
        outReady = 1'b0;
        shift_word(4'b1010);
        shift_word(4'b0110);
        checks++;
        if (parallelOut !== 4'b1010 || overrun !== 1'b1 || outValid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: pout=%b ovr=%b v=%b required 1010 1 1",
                     parallelOut, overrun, outValid);
        end
        step(1'b0, 1'b0);
        checks++;
        if (overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_sticky: ovr=%b required 1", overrun);
        end
        clear = 1'b1; step(1'b0, 1'b0); clear = 1'b0;
        checks++;
        if (overrun !== 1'b0 || bitCount !== '0 || outValid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_clear: ovr=%b cnt=%0d v=%b required 0 0 1",
                     overrun, bitCount, outValid);
        end
        outReady = 1'b1; step(1'b0, 1'b0); outReady = 1'b0;
        checks++;
        if (outValid !== 1'b0 || parallelOut !== 4'b1010) begin
            errors++;
            $display("FAIL consume: v=%b pout=%b required 0 1010", outValid, parallelOut);
        end
    endtask

    task automatic test_clear_mid_word;
        step(1'b1, 1'b1); step(1'b1, 1'b1);
        clear = 1'b1; step(1'b1, 1'b1); clear = 1'b0;
        checks++;
        if (regContent !== '0 || bitCount !== '0) begin
            errors++;
            $display("FAIL clear_mid: reg=%b cnt=%0d required 0000 0", regContent, bitCount);
        end
        shift_word(4'b0001);
        checks++;
        if (parallelOut !== 4'b0001 || outValid !== 1'b1 || regContent !== 4'b0001) begin
            errors++;
            $display("FAIL clear_word: pout=%b v=%b reg=%b required 0001 1 0001",
                     parallelOut, outValid, regContent);
        end
    endtask

    task automatic test_consume_and_complete;
        outReady = 1'b0;
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b0);
        outReady = 1'b1;
        step(1'b1, 1'b1);
        shiftEn = 1'b0; outReady = 1'b0;
        checks++;
        if (parallelOut !== 4'b1001 || outValid !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL consume_complete: pout=%b v=%b ovr=%b required 1001 1 0",
                     parallelOut, outValid, overrun);
        end
    endtask

    task automatic test_async_reset;
        logic [WIDTH-1:0] piso;
        step(1'b1, 1'b1); step(1'b1, 1'b0); shiftEn = 1'b0;
        checks++;
        if (outValid !== 1'b1 || bitCount !== CNT_W'(2)) begin
            errors++;
            $display("FAIL pre_reset: v=%b cnt=%0d required 1 2", outValid, bitCount);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({regContent, bitCount, parallelOut, outValid, overrun} !== '0) begin
            errors++;
            $display("FAIL async_reset: reg=%b cnt=%0d pout=%b v=%b ovr=%b, required all 0",
                     regContent, bitCount, parallelOut, outValid, overrun);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        // Behavioural PISO partner: load 1111, emit MSB first
        piso = 4'b1111;
        for (int i = 0; i < WIDTH; i++) begin
            step(1'b1, piso[WIDTH-1]);
            piso = piso << 1;
        end
        shiftEn = 1'b0;
        checks++;
        if (parallelOut !== 4'b1111 || outValid !== 1'b1) begin
            errors++;
            $display("FAIL loopback: pout=%b v=%b required 1111 1", parallelOut, outValid);
        end
    endtask

    initial begin
        rst_n = 1'b0; shiftIn = 1'b0; shiftEn = 1'b0; clear = 1'b0; outReady = 1'b0;
        #1;
        test_reset();
        test_gapped();
        test_back_to_back();
        test_overrun();
        test_clear_mid_word();
        test_consume_and_complete();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
